uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (async_transmitter: TxD_start/TxD_data in, TxD_busy out) among NUM_REQ byte requesters.
//  Round-robin arbitration; one byte per grant.
//  Sequences the transmitter start/busy handshake and acks each requester once its byte is accepted.
//  Sits between the lab's debug/report sources and the single serial TX pin path.
// PARAMETERS
//  NUM_REQ       4     number of requesters (2..8)
//  BUSY_TIMEOUT  16    clk cycles to wait for tx_busy to rise after tx_start before aborting
// PORTS
//  clk        in   1          system clock; all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  req        in   NUM_REQ    req[i]=1: requester i has a valid byte on data[8i+7:8i]
//  data       in   8*NUM_REQ  flattened request bytes, requester i at [8i+7:8i]
//  ack        out  NUM_REQ    one-cycle pulse: byte of requester i latched and sent to transmitter
//  grant_id   out  clog2(NUM_REQ)  index of current/last granted requester
//  tx_start   out  1          one-cycle start pulse to transmitter
//  tx_data    out  8          byte to transmitter, stable from tx_start until WAIT_DONE exits
//  tx_busy    in   1          transmitter busy
//  timeout_err out 1          sticky; set when tx_busy fails to rise within BUSY_TIMEOUT; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, ack=0, tx_start=0, tx_data=8'h00, grant_id=NUM_REQ-1 (so requester 0 wins first), timeout_err=0, timer=0.
//  IDLE: if |req and !tx_busy -> pick winner = first set req scanning grant_id+1, +2, ... modulo NUM_REQ.
//    Latch tx_data<=data[winner], grant_id<=winner -> START. Else stay.
//  START (1 cycle): tx_start=1, ack[grant_id]=1, timer cleared -> WAIT_BUSY.
//  WAIT_BUSY: tx_busy=1 -> WAIT_DONE.
//    Else timer++; when timer reaches BUSY_TIMEOUT-1 -> set timeout_err, -> IDLE.
//  WAIT_DONE: stay while tx_busy=1; tx_busy=0 -> IDLE.
//  Latency: req seen in IDLE -> tx_start 2 cycles later (IDLE registered decision, START). Min byte period = 3 cycles + transmitter busy time.
//  Requester contract: after its ack, requester drops req or presents next byte the following cycle. req sampled only in IDLE.
//  Simultaneous reqs: strictly rotating, no requester served twice while another waits (lock feature off).
//  Single requester: served back-to-back, no idle gap beyond the IDLE cycle.
//  tx_busy high in IDLE (foreign use or late deassert): no grant until low.
//  req dropped during START/WAIT_*: ignored, byte already committed.
//  rst mid-transfer: immediate return to reset values. Transmitter frame in flight is not aborted by this block.
//  Wrap-around: grant_id NUM_REQ-1 -> next search starts at 0. timer saturates, never wraps.
//  Outputs ack, tx_start, tx_data, grant_id are registered (no combinational path from req/tx_busy).
// CONFIGURATION
//  UART_ARB_LOCK_EN defined: extra input req_lock [NUM_REQ-1:0].
//    If req_lock[grant_id]=1 and req[grant_id]=1 in IDLE, same requester is re-granted, bypassing rotation (multi-byte packets stay contiguous).
//    Lock is honoured for at most 16 consecutive bytes, then rotation is forced for one grant.
//  UART_ARB_LOCK_EN undefined: no req_lock port; pure round-robin as above.
// STRUCTURE
//  Shared include uart_arb_defs.vh: state encodings (IDLE=2'd0, START=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3) and lock burst limit constant (16).
//  Sub-module rr_pick (combinational): inputs req, last-grant index; outputs winner index and valid.
//  Top holds FSM, timer, data latch.
// TESTING
//  1 Reset then req=4'b0001, data0=8'hA5, model busy 1 cycle after start for 20 cycles.
//    -> ack[0] and tx_start same cycle, tx_data=8'hA5, one byte only.
//  2 req=4'b1111 held, each requester re-presents after ack.
//    -> grant order 0,1,2,3,0,1,... and tx_data matches each source.
//  3 req=4'b1010, grant_id=1 before arbitration -> next grant 3, then 1.
//  4 tx_busy never rises after tx_start, BUSY_TIMEOUT=16.
//    -> timeout_err=1 exactly 16 cycles after START; FSM back in IDLE, next req served.
//  5 rst asserted during WAIT_DONE.
//    -> next cycle: ack=0, tx_start=0, tx_data=8'h00, grant_id=NUM_REQ-1, timeout_err=0.
//  6 (UART_ARB_LOCK_EN) req=4'b0011, req_lock[0]=1 -> 16 consecutive grants to 0, then one to 1, then 0 again.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings
// and the lock burst limit used when UART_ARB_LOCK_EN is defined.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  // Maximum number of consecutive bytes one locked requester may send
  // before rotation is forced for one grant.
  localparam int LOCK_BURST_MAX = 16;
  localparam int LOCK_CNT_W     = $clog2(LOCK_BURST_MAX + 1);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bundle of the UART transmit arbiter.
// master: the arbiter itself (drives acks and the transmitter start/data).
// slave : the surrounding requesters and transmitter.
// Optional req_lock exists only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]   ack;
  logic [IDW-1:0]       grant_id;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 timeout_err;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   req_lock;

  modport master (
    input  req, data, req_lock, tx_busy,
    output ack, grant_id, tx_start, tx_data, timeout_err
  );
  modport slave (
    output req, data, req_lock, tx_busy,
    input  ack, grant_id, tx_start, tx_data, timeout_err
  );
`else
  modport master (
    input  req, data, tx_busy,
    output ack, grant_id, tx_start, tx_data, timeout_err
  );
  modport slave (
    output req, data, tx_busy,
    input  ack, grant_id, tx_start, tx_data, timeout_err
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning
// last_i+1, last_i+2, ... modulo NUM_REQ. The last winner is checked last,
// so a lone requester is still picked.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_i,
  output logic [IDW-1:0]     winner_o,
  output logic               valid_o
);

  logic [IDW-1:0] cand;

  // Scan in rotation order and keep the first requester found.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(last_i) + i) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters, one byte per
// grant, round-robin. Optional feature macro: UART_ARB_LOCK_EN (adds
// req_lock so a requester can keep the transmitter for up to
// LOCK_BURST_MAX consecutive bytes).
//
// state        | meaning
// ST_IDLE      | waiting for a request while the transmitter is free
// ST_START     | tx_start and ack pulse out, byte committed
// ST_WAIT_BUSY | waiting for tx_busy to rise, abort on timeout
// ST_WAIT_DONE | transmitter busy, waiting for it to finish
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
  // The abort fires on the cycle the timer steps to BUSY_TIMEOUT-1, which
  // puts timeout_err up BUSY_TIMEOUT cycles after the tx_start pulse.
  localparam logic [TW-1:0] TIMER_ABORT = TW'(BUSY_TIMEOUT - 2);
  localparam logic [TW-1:0] TIMER_MAX   = TW'(BUSY_TIMEOUT - 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           err_q, err_d;
  logic           start_q, start_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic [7:0]     req_byte [NUM_REQ];
  logic [IDW-1:0] pick_id;
  logic           pick_valid;
  logic [IDW-1:0] winner;

  // Unpack the flattened request bytes.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = bus.data[8*i +: 8];
    end
  end

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i    (bus.req),
    .last_i   (grant_q),
    .winner_o (pick_id),
    .valid_o  (pick_valid)
  );

`ifdef UART_ARB_LOCK_EN
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  lock_hit;

  assign lock_hit = bus.req_lock[grant_q] && bus.req[grant_q] &&
                    (lock_cnt_q < LOCK_CNT_W'(LOCK_BURST_MAX));
  assign winner   = lock_hit ? grant_q : pick_id;
`else
  assign winner   = pick_id;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    timer_d   = timer_q;
    err_d     = err_q;
    start_d   = 1'b0;
    ack_d     = '0;
`ifdef UART_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid && !bus.tx_busy) begin
          state_d       = ST_START;
          grant_d       = winner;
          tx_data_d     = req_byte[winner];
          start_d       = 1'b1;
          ack_d[winner] = 1'b1;
`ifdef UART_ARB_LOCK_EN
          lock_cnt_d    = lock_hit ? lock_cnt_q + LOCK_CNT_W'(1) : LOCK_CNT_W'(1);
`endif
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q >= TIMER_ABORT) begin
          timer_d = TIMER_MAX;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= IDW'(NUM_REQ - 1);
      tx_data_q <= 8'h00;
      timer_q   <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      ack_q     <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
`ifdef UART_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus.ack         = ack_q;
  assign bus.grant_id    = grant_q;
  assign bus.tx_start    = start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued when a
// requester is loaded and compared when the arbiter acks.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int BT = 16;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         rem [NR];
  logic [7:0] rq_byte [NR];
  int         cyc = 0;
  int         start_cyc = 0;
  logic       model_en = 1'b1;
  int         busy_len = 3;
  int         busy_cnt = 0;
  exp_t       mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] b);
    exp_t e;
    e.id = id;
    e.b  = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    for (int n = 0; n < max_cyc && exp_q.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_rst_ack"},      bus.ack, 0);
    chk({tag, "_rst_tx_start"}, bus.tx_start, 0);
    chk({tag, "_rst_tx_data"},  bus.tx_data, 8'h00);
    chk({tag, "_rst_grant_id"}, bus.grant_id, NR - 1);
    chk({tag, "_rst_timeout"},  bus.timeout_err, 0);
    rst = 1'b0;
  endtask

  // Requesters: req follows the remaining byte count, data the current byte.
  always_comb begin
    bus.req  = '0;
    bus.data = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req[i]         = (rem[i] > 0);
      bus.data[8*i +: 8] = rq_byte[i];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises the cycle after tx_start, lasts busy_len.
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) bus.tx_busy = 1'b0;
    end else if (model_en && bus.tx_start) begin
      bus.tx_busy = 1'b1;
      busy_cnt    = busy_len;
    end
  end

  // Monitor: compare each ack against the scoreboard, then advance requester.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_start) start_cyc = cyc;
      if (bus.ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", bus.ack, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_id",   bus.grant_id, mon_e.id);
          chk("tx_data",    bus.tx_data, mon_e.b);
          chk("ack_onehot", bus.ack, 32'(1) << mon_e.id);
          chk("tx_start",   bus.tx_start, 1);
        end
        for (int i = 0; i < NR; i++) begin
          if (bus.ack[i] && rem[i] > 0) begin
            rem[i]     = rem[i] - 1;
            rq_byte[i] = rq_byte[i] + 8'd1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t_err;
    logic saw;
    for (int i = 0; i < NR; i++) begin
      rem[i]     = 0;
      rq_byte[i] = 8'h00;
    end
    bus.tx_busy = 1'b0;
`ifdef UART_ARB_LOCK_EN
    bus.req_lock = '0;
`endif

    // Single byte from requester 0.
    do_reset("t1");
    push_exp(2'd0, 8'hA5);
    rq_byte[0] = 8'hA5;
    rem[0]     = 1;
    wait_drain("t1", 60);
    repeat (20) @(negedge clk);
    chk("t1_tx_data_hold", bus.tx_data, 8'hA5);
    chk("t1_grant_hold",   bus.grant_id, 0);

    // All four requesting, each re-presents after its ack.
    do_reset("t2");
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++)
        push_exp(2'(i), 8'(8'h10 * (i + 1) + k));
    for (int i = 0; i < NR; i++) begin
      rq_byte[i] = 8'(8'h10 * (i + 1));
      rem[i]     = 2;
    end
    wait_drain("t2", 300);

    // req 1010 with last grant 1: expect 3 then 1.
    do_reset("t3");
    push_exp(2'd1, 8'h21);
    rq_byte[1] = 8'h21;
    rem[1]     = 1;
    wait_drain("t3a", 60);
    chk("t3_grant_before", bus.grant_id, 1);
    push_exp(2'd3, 8'h3C);
    push_exp(2'd1, 8'h22);
    rq_byte[3] = 8'h3C;
    rem[1]     = 1;
    rem[3]     = 1;
    wait_drain("t3b", 100);

    // Transmitter never goes busy: timeout after BUSY_TIMEOUT cycles.
    model_en = 1'b0;
    push_exp(2'd2, 8'h5A);
    rq_byte[2] = 8'h5A;
    rem[2]     = 1;
    t_err      = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.timeout_err) begin
        t_err = cyc;
        break;
      end
    end
    chk("t4_timeout_seen",  bus.timeout_err, 1);
    chk("t4_timeout_delay", t_err - start_cyc, BT);
    chk("t4_drain",         exp_q.size(), 0);
    model_en = 1'b1;
    push_exp(2'd3, 8'h77);
    rq_byte[3] = 8'h77;
    rem[3]     = 1;
    wait_drain("t4_after", 60);
    chk("t4_sticky", bus.timeout_err, 1);

    // Reset during WAIT_DONE, then hold-off while transmitter still busy.
    busy_len = 30;
    push_exp(2'd0, 8'h99);
    rq_byte[0] = 8'h99;
    rem[0]     = 1;
    wait_drain("t5a", 40);
    for (int n = 0; n < 20 && !bus.tx_busy; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t5_busy_before_rst", bus.tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ack",      bus.ack, 0);
    chk("t5_rst_tx_start", bus.tx_start, 0);
    chk("t5_rst_tx_data",  bus.tx_data, 8'h00);
    chk("t5_rst_grant_id", bus.grant_id, NR - 1);
    chk("t5_rst_timeout",  bus.timeout_err, 0);
    rst = 1'b0;
    push_exp(2'd1, 8'h31);
    rq_byte[1] = 8'h31;
    rem[1]     = 1;
    saw        = 1'b0;
    for (int n = 0; n < 60 && bus.tx_busy; n++) begin
      @(negedge clk);
      if (bus.ack != '0 && bus.tx_busy) saw = 1'b1;
    end
    chk("t5_no_grant_while_busy", saw, 0);
    wait_drain("t5b", 60);
    busy_len = 3;

`ifdef UART_ARB_LOCK_EN
    // Locked requester 0: 16 bytes, forced rotation to 1, then 0 again.
    do_reset("t6");
    bus.req_lock = 4'b0001;
    for (int k = 0; k < 16; k++) push_exp(2'd0, 8'(8'h50 + k));
    push_exp(2'd1, 8'h80);
    push_exp(2'd0, 8'h60);
    rq_byte[0] = 8'h50;
    rq_byte[1] = 8'h80;
    rem[0]     = 17;
    rem[1]     = 1;
    wait_drain("t6", 500);
    bus.req_lock = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
